vmsu_pipe: RTL and testbench

- Parametrised, pipelined successor to the 8-bit Vedic signed/unsigned multiplier.
- Multiplies two W-bit operands in signed or unsigned mode, selected per transaction.
- Uses sign-magnitude conversion and an Urdhva-Tiryagbhyam (Vedic) unsigned core split into four half-width partial products.
- Has valid/ready handshakes on both sides and a tag passthrough, so it can sit behind a Wishbone/LA bridge or a DMA-fed stream.

---
 rtl/vmsu_pkg.sv | 29 ++
 rtl/vmsu_vedic_core.sv | 38 +++
 rtl/vmsu_pipe.sv | 150 +++++++++++++++
 tb/tb_vmsu_pipe.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vmsu_pkg.sv
// Shared definitions for the pipelined Vedic signed/unsigned multiplier.
package vmsu_pkg;

  // Number of register stages between an accepted operand pair and its product.
  localparam int VMSU_LAT = 4;

  // Widest product the negate helper handles (W up to 32).
  localparam int VMSU_MAX_P = 64;

  // Per-stage control sideband. The top wraps this together with its
  // parameter-width tag to form the full stage record.
  typedef struct packed {
    logic valid;
    logic sign_neg;
    logic signed_mode;
  } vmsu_ctl_t;

  // Two's-complement negate; callers size-cast the result back to 2W bits,
  // which keeps the low bits exact because negation is width-truncation safe.
  function automatic logic [VMSU_MAX_P-1:0] vmsu_neg(input logic [VMSU_MAX_P-1:0] x);
    return ~x + VMSU_MAX_P'(1);
  endfunction

  // Number of set bits in a 4-bit stage-valid vector.
  function automatic logic [2:0] vmsu_popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/vmsu_vedic_core.sv
// Combinational unsigned N x N -> 2N Urdhva-Tiryagbhyam multiplier.
// Splits each operand into halves, recurses down to a 2x2 gate-level base.
module vmsu_vedic_core
  import vmsu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic [2*N-1:0] o_p
);

  if (N == 2) begin : g_base
    logic w_t1, w_t2, w_t3, w_c1;

    // Vertical and crosswise terms of the 2x2 base case.
    assign w_t1 = i_a[1] & i_b[0];
    assign w_t2 = i_a[0] & i_b[1];
    assign w_t3 = i_a[1] & i_b[1];
    assign w_c1 = w_t1 & w_t2;
    assign o_p  = {w_t3 & w_c1, w_t3 ^ w_c1, w_t1 ^ w_t2, i_a[0] & i_b[0]};
  end else begin : g_rec
    localparam int M = N / 2;

    logic [N-1:0] w_ll, w_lh, w_hl, w_hh;
    logic [N:0]   w_mid;

    vmsu_vedic_core #(.N(M)) u_ll (.i_a(i_a[M-1:0]), .i_b(i_b[M-1:0]), .o_p(w_ll));
    vmsu_vedic_core #(.N(M)) u_lh (.i_a(i_a[M-1:0]), .i_b(i_b[N-1:M]), .o_p(w_lh));
    vmsu_vedic_core #(.N(M)) u_hl (.i_a(i_a[N-1:M]), .i_b(i_b[M-1:0]), .o_p(w_hl));
    vmsu_vedic_core #(.N(M)) u_hh (.i_a(i_a[N-1:M]), .i_b(i_b[N-1:M]), .o_p(w_hh));

    // Crosswise sum keeps its carry; vertical terms concatenate without overlap.
    assign w_mid = {1'b0, w_lh} + {1'b0, w_hl};
    assign o_p   = {w_hh, w_ll} + ((2 * N)'(w_mid) << M);
  end

endmodule

// File: rtl/vmsu_pipe.sv
// Four-stage pipelined signed/unsigned multiplier with valid/ready on both
// sides, tag passthrough and a registered occupancy count.
// Stages: S0 magnitudes+sign, S1 partial products, S2 aligned sum, S3 result.
module vmsu_pipe
  import vmsu_pkg::*;
#(
  parameter int W     = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             signed_mode,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   p,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_signed,
  output logic [2:0]       occupancy
);

  localparam int H  = W / 2;
  localparam int P2 = 2 * W;

  typedef struct packed {
    vmsu_ctl_t        ctl;
    logic [TAG_W-1:0] tag;
  } side_t;

  side_t               r_side [VMSU_LAT];
  logic [W-1:0]        r_mag_a, r_mag_b;
  logic [W-1:0]        r_pp   [4];
  logic [P2-1:0]       r_sum;
  logic [P2-1:0]       r_p;
  logic [2:0]          r_occ;

  logic                w_stall;
  side_t               w_side_in;
  logic [W-1:0]        w_mag_a, w_mag_b;
  logic [W-1:0]        w_pp   [4];
  logic [W:0]          w_mid;
  logic [P2-1:0]       w_sum;
  logic [P2-1:0]       w_p;
  logic [VMSU_LAT-1:0] w_valid_next;

  // Whole pipeline freezes while the output holds an unaccepted result.
  assign w_stall  = r_side[VMSU_LAT-1].ctl.valid & ~out_ready;
  assign in_ready = ~w_stall;

  // Sign-magnitude conversion; -(-2^(W-1)) wraps to 2^(W-1), exact as unsigned.
  always_comb begin
    w_mag_a = a;
    w_mag_b = b;
    if (signed_mode && a[W-1]) w_mag_a = -a;
    if (signed_mode && b[W-1]) w_mag_b = -b;
    w_side_in                 = '0;
    w_side_in.ctl.valid       = in_valid;
    w_side_in.ctl.sign_neg    = signed_mode & (a[W-1] ^ b[W-1]);
    w_side_in.ctl.signed_mode = signed_mode;
    w_side_in.tag             = tag;
  end

  // Four half-width partial products: 0=LL, 1=LH (a lo, b hi), 2=HL, 3=HH.
  for (genvar gi = 0; gi < 4; gi++) begin : g_pp
    localparam bit A_HI = (gi >= 2);
    localparam bit B_HI = ((gi % 2) == 1);

    vmsu_vedic_core #(.N(H)) u_core (
      .i_a (A_HI ? r_mag_a[W-1:H] : r_mag_a[H-1:0]),
      .i_b (B_HI ? r_mag_b[W-1:H] : r_mag_b[H-1:0]),
      .o_p (w_pp[gi])
    );
  end

  // Alignment of the partial products and final sign application.
  always_comb begin
    w_mid = {1'b0, r_pp[1]} + {1'b0, r_pp[2]};
    w_sum = {r_pp[3], r_pp[0]} + (P2'(w_mid) << H);
    w_p   = r_side[2].ctl.sign_neg ? P2'(vmsu_neg(VMSU_MAX_P'(r_sum))) : r_sum;
  end

  // Valid bits each stage will hold after the next advancing edge.
  always_comb begin
    w_valid_next[0] = in_valid;
    for (int i = 1; i < VMSU_LAT; i++) begin
      w_valid_next[i] = r_side[i-1].ctl.valid;
    end
  end

  // Sideband shift: valid/sign/mode/tag move in lockstep with the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < VMSU_LAT; i++) r_side[i] <= '0;
    end else if (!w_stall) begin
      r_side[0] <= w_side_in;
      for (int i = 1; i < VMSU_LAT; i++) r_side[i] <= r_side[i-1];
    end
  end

  // S0 data: operand magnitudes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mag_a <= '0;
      r_mag_b <= '0;
    end else if (!w_stall) begin
      r_mag_a <= w_mag_a;
      r_mag_b <= w_mag_b;
    end
  end

  // S1 data: partial products.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_pp[i] <= '0;
    end else if (!w_stall) begin
      for (int i = 0; i < 4; i++) r_pp[i] <= w_pp[i];
    end
  end

  // S2 and S3 data: unsigned sum, then the signed output product.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum <= '0;
      r_p   <= '0;
    end else if (!w_stall) begin
      r_sum <= w_sum;
      r_p   <= w_p;
    end
  end

  // Occupancy tracks the valid bits being loaded on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ <= '0;
    end else if (!w_stall) begin
      r_occ <= vmsu_popcount4(w_valid_next);
    end
  end

  assign out_valid  = r_side[VMSU_LAT-1].ctl.valid;
  assign out_tag    = r_side[VMSU_LAT-1].tag;
  assign out_signed = r_side[VMSU_LAT-1].ctl.signed_mode;
  assign p          = r_p;
  assign occupancy  = r_occ;

endmodule

// File: tb/tb_vmsu_pipe.sv
// Self-checking bench for vmsu_pipe (W=8): directed corner products, a
// random back-to-back stream, a stall window and a mid-flight reset, all
// scored against a plain-arithmetic reference model and an in-order queue.
module tb_vmsu_pipe;

  localparam int W     = 8;
  localparam int TAG_W = 4;
  localparam int P2    = 2 * W;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             signed_mode;
  logic [TAG_W-1:0] tag;
  logic             out_valid;
  logic             out_ready;
  logic [P2-1:0]    p;
  logic [TAG_W-1:0] out_tag;
  logic             out_signed;
  logic [2:0]       occupancy;

  typedef struct {
    logic [P2-1:0]    p;
    logic [TAG_W-1:0] tag;
    logic             sm;
    int               cyc;
    int               stall_at;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   nchk      = 0;
  int   npass     = 0;
  int   nfail     = 0;
  int   cyc       = 0;
  int   stall_cnt = 0;
  int   max_occ   = 0;

  vmsu_pipe #(.W(W), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .tag         (tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .p           (p),
    .out_tag     (out_tag),
    .out_signed  (out_signed),
    .occupancy   (occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference product straight from integer arithmetic.
  function automatic logic [P2-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic sm);
    longint          sx, sy;
    longint unsigned ux, uy;
    if (sm) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return P2'(sx * sy);
    end
    ux = 64'(x);
    uy = 64'(y);
    return P2'(ux * uy);
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(W-1){1'b0}}};
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sm,
                       input logic [TAG_W-1:0] tg);
    in_valid    = 1'b1;
    a           = av;
    b           = bv;
    signed_mode = sm;
    tag         = tg;
    cur.p       = model(av, bv, sm);
    cur.tag     = tg;
    cur.sm      = sm;
  endtask

  task automatic drive_exp(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sm,
                           input logic [TAG_W-1:0] tg, input logic [P2-1:0] expp);
    drive(av, bv, sm, tg);
    cur.p = expp;
  endtask

  task automatic drive_rand();
    drive(rand_op(), rand_op(), 1'($urandom), TAG_W'($urandom));
  endtask

  // One clock: score transfers seen this cycle, advance, then check occupancy.
  task automatic cycle();
    logic acc, otx;
    exp_t e;
    acc = in_valid && in_ready && !rst;
    otx = out_valid && out_ready && !rst;
    if (out_valid && !out_ready && !rst) stall_cnt++;
    if (otx) begin
      if (q.size() == 0) begin
        check("spurious_out", 64'(out_valid), 64'd0);
      end else begin
        e = q.pop_front();
        check("p", 64'(p), 64'(e.p));
        check("out_tag", 64'(out_tag), 64'(e.tag));
        check("out_signed", 64'(out_signed), 64'(e.sm));
        if (e.stall_at == stall_cnt) check("latency", 64'(cyc - e.cyc), 64'd4);
        $display("txn out cyc=%0d tag=%0h signed=%0b p=%0h", cyc, out_tag, out_signed, p);
      end
    end
    if (acc) begin
      cur.cyc      = cyc;
      cur.stall_at = stall_cnt;
      q.push_back(cur);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) q.delete();
    check("occupancy", 64'(occupancy), 64'(q.size()));
    if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    a           = '0;
    b           = '0;
    signed_mode = 1'b0;
    tag         = '0;
    out_ready   = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;

    // Reset state.
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_p", 64'(p), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_out_signed", 64'(out_signed), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Unsigned 255*255.
    drive_exp(8'hFF, 8'hFF, 1'b0, 4'h1, 16'hFE01);
    cycle();
    in_valid = 1'b0;
    repeat (6) cycle();

    // Signed corner products, back to back.
    drive_exp(8'h80, 8'h80, 1'b1, 4'h2, 16'h4000);
    cycle();
    drive_exp(8'h80, 8'h7F, 1'b1, 4'h3, 16'hC080);
    cycle();
    drive_exp(8'hFF, 8'h01, 1'b1, 4'h4, 16'hFFFF);
    cycle();
    drive_exp(8'h00, 8'hFB, 1'b1, 4'h5, 16'h0000);
    cycle();
    in_valid = 1'b0;
    repeat (8) cycle();

    // Random back-to-back stream with the sink always ready.
    for (int i = 0; i < 100; i++) begin
      drive_rand();
      check("stream_in_ready", 64'(in_ready), 64'd1);
      cycle();
    end
    in_valid = 1'b0;
    repeat (8) cycle();
    check("occ_max", 64'(max_occ), 64'd4);
    check("stream_drained", 64'(q.size()), 64'd0);

    // Stall: fill with the sink blocked, keep offering inputs.
    out_ready = 1'b0;
    for (int i = 0; i < 20 && in_ready; i++) begin
      drive_rand();
      cycle();
    end
    for (int i = 0; i < 5; i++) begin
      drive_rand();
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_occ", 64'(occupancy), 64'd4);
      if (q.size() > 0) begin
        check("stall_p", 64'(p), 64'(q[0].p));
        check("stall_tag", 64'(out_tag), 64'(q[0].tag));
      end
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) cycle();
    check("stall_drained", 64'(q.size()), 64'd0);
    repeat (4) cycle();

    // Reset with three transactions in flight and the sink blocked.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      cycle();
    end
    rst = 1'b1;
    drive_rand();
    cycle();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_p", 64'(p), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_out_tag", 64'(out_tag), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("no_stale", 64'(out_valid), 64'd0);
      cycle();
    end

    // A final directed pair after reset to show the pipe is usable again.
    drive_exp(8'h80, 8'h80, 1'b0, 4'hA, 16'h4000);
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) cycle();
    check("final_drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
